// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: digit/segment widths, blank
// patterns and the segment bit order {g,f,e,d,c,b,a}.
package clock_pkg;

   localparam int SEG_W    = 7;
   localparam int N_DIGITS = 4;

   localparam logic [SEG_W-1:0]    SEG_BLANK = 7'h7F;
   localparam logic [N_DIGITS-1:0] AN_OFF    = 4'b1111;

   typedef enum logic [2:0] {
      SEG_A = 3'd0,
      SEG_B = 3'd1,
      SEG_C = 3'd2,
      SEG_D = 3'd3,
      SEG_E = 3'd4,
      SEG_F = 3'd5,
      SEG_G = 3'd6
   } seg_bit_e;

   typedef logic [SEG_W-1:0] seg_t;
   typedef logic [1:0]       digit_idx_t;

   // Active-low one-hot digit enable for the given digit index.
   function automatic logic [N_DIGITS-1:0] an_select(input digit_idx_t idx);
      an_select = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Slot prescaler for display_scan: owns the in-slot counter and the digit
// index, and decodes the slot/frame wrap and blank-phase strobes.
module refresh_prescaler
   import clock_pkg::*;
#(
   parameter int DIV_REFRESH  = 12500,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   output digit_idx_t idx_o,
   output logic       slot_wrap_o,
   output logic       frame_wrap_o,
   output logic       in_blank_o
);

   localparam int CNT_W = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_REFRESH - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         idx_d = idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx_o        = idx_q;
   assign slot_wrap_o  = (cnt_q == CNT_LAST);
   assign frame_wrap_o = (cnt_q == '0) && (idx_q == 2'd0);
   assign in_blank_o   = (cnt_q < BLANK_END);

endmodule

// File: rtl/display_scan.sv
// Four-digit time-multiplexed seven-segment driver with per-slot blanking and
// once-per-frame snapshots. Define DISPLAY_SCAN_BLINK_EN to build digit blink.
module display_scan
   import clock_pkg::*;
#(
   parameter int DIV_REFRESH  = 12500,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 60
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SEG_W-1:0]    display3,
   input  logic [SEG_W-1:0]    display2,
   input  logic [SEG_W-1:0]    display1,
   input  logic [SEG_W-1:0]    display0,
   input  logic [N_DIGITS-1:0] blink_mask,
   output logic [SEG_W-1:0]    seg,
   output logic [N_DIGITS-1:0] an,
   output logic                frame_start
);

   digit_idx_t          idx_s;
   logic                slot_wrap_s, frame_wrap_s, in_blank_s, dark_s;
   seg_t                shadow_q [N_DIGITS];
   seg_t                seg_d, seg_q;
   logic [N_DIGITS-1:0] an_d, an_q;
   logic                frame_start_q;

   refresh_prescaler #(
      .DIV_REFRESH (DIV_REFRESH),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .idx_o       (idx_s),
      .slot_wrap_o (slot_wrap_s),
      .frame_wrap_o(frame_wrap_s),
      .in_blank_o  (in_blank_s)
   );

   // Frame snapshot: digits only ever display these copies, so no tearing.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_DIGITS; i++) shadow_q[i] <= SEG_BLANK;
      end else if (frame_wrap_s) begin
         shadow_q[0] <= display0;
         shadow_q[1] <= display1;
         shadow_q[2] <= display2;
         shadow_q[3] <= display3;
      end
   end

`ifdef DISPLAY_SCAN_BLINK_EN
   localparam int FR_W = $clog2(BLINK_FRAMES + 1);

   logic [FR_W-1:0]     frame_cnt_q;
   logic                blink_phase_q;
   logic [N_DIGITS-1:0] mask_q;
   logic                frame_end_s;

   assign frame_end_s = slot_wrap_s && (idx_s == 2'd3);

   // Blink phase flips as each run of BLINK_FRAMES frames completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         mask_q        <= '0;
      end else begin
         if (frame_wrap_s) mask_q <= blink_mask;
         if (frame_end_s) begin
            if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
               frame_cnt_q   <= '0;
               blink_phase_q <= ~blink_phase_q;
            end else begin
               frame_cnt_q <= frame_cnt_q + FR_W'(1);
            end
         end
      end
   end

   assign dark_s = blink_phase_q & mask_q[idx_s];
`else
   logic unused_blink_s;
   assign unused_blink_s = ^{blink_mask, slot_wrap_s};
   assign dark_s         = 1'b0;
`endif

   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
      if (in_blank_s || dark_s) begin
         seg_d = SEG_BLANK;
         an_d  = AN_OFF;
      end else begin
         seg_d = shadow_q[idx_s];
         an_d  = an_select(idx_s);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q         <= SEG_BLANK;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_wrap_s;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized self-checking bench for display_scan against a timeline model.
module tb_display_scan;

   localparam int DIV = 8;
   localparam int BLK = 2;
   localparam int BF  = 2;
   localparam int FRAME = 4 * DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] d0, d1, d2, d3;
   logic [3:0] mask;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_start;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         pos;
   logic [6:0] sh_m [4];
   logic [3:0] shm_m;
   logic [6:0] exp_seg;
   logic [3:0] exp_an;
   logic       exp_fs;

   display_scan #(.DIV_REFRESH(DIV), .BLANK_CYCLES(BLK), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset),
      .display3(d3), .display2(d2), .display1(d1), .display0(d0),
      .blink_mask(mask), .seg(seg), .an(an), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at pos=%0d got=%0h expected=%0h", tag, pos, got, want);
      end
   endtask

   // Expected outputs for the next cycle, from time since reset release.
   task automatic model_cycle();
      int  cnt, idx, frame;
      bit  blank;
      if (reset) begin
         exp_seg = 7'h7F; exp_an = 4'hF; exp_fs = 1'b0;
         pos = 0;
         for (int i = 0; i < 4; i++) sh_m[i] = 7'h7F;
         shm_m = 4'h0;
      end else begin
         cnt   = pos % DIV;
         idx   = (pos / DIV) % 4;
         frame = pos / FRAME;
         if (pos % FRAME == 0) begin
            sh_m[0] = d0; sh_m[1] = d1; sh_m[2] = d2; sh_m[3] = d3;
            shm_m = mask;
         end
         exp_fs = (pos % FRAME == 0);
         blank  = (cnt < BLK);
`ifdef DISPLAY_SCAN_BLINK_EN
         if (((frame / BF) % 2 == 1) && shm_m[idx]) blank = 1'b1;
`endif
         exp_an  = blank ? 4'hF : ~(4'b0001 << idx);
         exp_seg = blank ? 7'h7F : sh_m[idx];
         pos++;
      end
   endtask

   task automatic cycle();
      model_cycle();
      @(posedge clk); #1;
      check_val("seg", {25'd0, seg}, {25'd0, exp_seg});
      check_val("an", {28'd0, an}, {28'd0, exp_an});
      check_val("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
      check_val("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      d0 = 7'h40; d1 = 7'h79; d2 = 7'h24; d3 = 7'h30;
      mask = 4'b0011;
      pos = 0;
      for (int i = 0; i < 3; i++) cycle();
      reset = 1'b0;

      // scan order "0123", then tear attempt on digit 2 during idx=1
      for (int i = 0; i < 2 * FRAME + 10; i++) cycle();
      d2 = 7'h12;
      // blink pattern over several frames with a fixed mask
      for (int i = 0; i < 5 * FRAME; i++) cycle();

      // randomized inputs
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            case ($urandom_range(3, 0))
               0: d0 = 7'($urandom);
               1: d1 = 7'($urandom);
               2: d2 = 7'($urandom);
               default: d3 = 7'($urandom);
            endcase
         end
         if ($urandom_range(31, 0) == 0) mask = 4'($urandom);
         cycle();
      end

      // mid-scan reset at idx=2, cnt=5
      n = 0;
      while ((pos % FRAME) != (2 * DIV + 5) && n < 2 * FRAME) begin
         cycle();
         n++;
      end
      check_val("reach_idx2_cnt5", {31'd0, ((pos % FRAME) == (2 * DIV + 5))}, 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      d0 = 7'h06; d1 = 7'h5B; d2 = 7'h4F; d3 = 7'h66;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (i == 1) begin d0 = 7'h7E; d3 = 7'h01; end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
